// File: rtl/mac_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_pkg
// Brief    : Shared types and helpers for the weight-stationary MAC array.
// Revision : 1.0 - initial release
// ============================================================================
package mac_array_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } ld_state_t;

    function automatic int row_cnt_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Operands arrive sign-extended to 64 bits, so the raw sum cannot overflow.
    function automatic longint sat_add(input longint a, input longint b, input int pw);
        longint s;
        longint hi;
        longint lo;
        s  = a + b;
        hi = (64'sd1 <<< (pw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (pw - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe
// Brief    : One weight-stationary PE; saturating add when MAC_ARRAY_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_pe
    import mac_array_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [DW-1:0] W_IN,
    input  logic          ENTop,
    output logic          ENDown,
    input  logic          ENLeft,
    output logic          ENRight,
    input  logic [DW-1:0] A_IN,
    output logic [DW-1:0] A_OUT,
    input  logic [PW-1:0] PSUM_IN,
    output logic [PW-1:0] PSUM_OUT
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [PW-1:0]   w_prod_ext;
    logic        [PW-1:0]   w_sum;

    assign w_prod     = $signed(A_IN) * $signed(W_IN);
    assign w_prod_ext = PW'(w_prod);

`ifdef MAC_ARRAY_SAT_EN
    assign w_sum = PW'(sat_add($signed(PSUM_IN), w_prod_ext, PW));
`else
    assign w_sum = PSUM_IN + w_prod_ext;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            A_OUT    <= '0;
            PSUM_OUT <= '0;
            ENDown   <= 1'b0;
            ENRight  <= 1'b0;
        end else begin
            if (ENTop)
                A_OUT <= A_IN;
            if (ENLeft)
                PSUM_OUT <= w_sum;
            ENDown  <= ENTop;
            ENRight <= ENLeft;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_array_ws.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_ws
// Brief    : ROWS x COLS weight-stationary systolic MAC array with a
//            double-buffered weight bank. MAC_ARRAY_SAT_EN selects saturation.
// Revision : 1.0 - initial release
// ============================================================================
module mac_array_ws
    import mac_array_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int PW   = 16
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               W_VALID,
    output logic               W_READY,
    input  logic [COLS*DW-1:0] WDATA,
    input  logic [COLS*DW-1:0] IDATA,
    input  logic [COLS-1:0]    ICOL_VALID,
    output logic [ROWS*PW-1:0] ODATA,
    output logic [ROWS-1:0]    OVALID,
    output logic               W_ACTIVE,
    output logic               BUSY
);

    localparam int CW = row_cnt_w(ROWS);

    ld_state_t        r_state;
    ld_state_t        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_hs;
    logic             w_last;
    logic             w_swap;
    logic             r_w_active;

    logic [DW-1:0]    r_shadow [ROWS][COLS];
    logic [DW-1:0]    r_active [ROWS][COLS];

    logic [DW-1:0]    w_a_in   [ROWS][COLS];
    logic [DW-1:0]    w_a_out  [ROWS][COLS];
    logic [PW-1:0]    w_ps_in  [ROWS][COLS];
    logic [PW-1:0]    w_ps_out [ROWS][COLS];
    logic [ROWS*COLS-1:0] w_en_top;
    logic [ROWS*COLS-1:0] w_en_left;
    logic [ROWS*COLS-1:0] w_en_down;
    logic [ROWS*COLS-1:0] w_en_right;

    // ---------------- loader FSM ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, FILL: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt = FULL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = FILL;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (w_swap) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The swap waits for an empty array so in-flight vectors keep the old weights.
    always_comb begin
        W_READY = RSTN && (r_state != FULL);
        w_hs    = W_VALID && W_READY;
        w_last  = (r_cnt == CW'(ROWS - 1));
        w_swap  = (r_state == FULL) && !BUSY && (ICOL_VALID == '0);
    end

    // ---------------- weight banks ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    r_shadow[i][j] <= '0;
        end else if (w_hs) begin
            for (int j = 0; j < COLS; j++)
                r_shadow[r_cnt][j] <= WDATA[(COLS-1-j)*DW +: DW];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    r_active[i][j] <= '0;
            r_w_active <= 1'b0;
        end else if (w_swap) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    r_active[i][j] <= r_shadow[i][j];
            r_w_active <= 1'b1;
        end
    end

    assign W_ACTIVE = r_w_active;

    // ---------------- PE grid ----------------
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            localparam int K = i*COLS + j;

            if (i == 0) begin : g_top
                assign w_a_in[i][j] = IDATA[(COLS-1-j)*DW +: DW];
                assign w_en_top[K]  = ICOL_VALID[j];
            end else begin : g_below
                assign w_a_in[i][j] = w_a_out[i-1][j];
                assign w_en_top[K]  = w_en_down[K-COLS];
            end

            if (j == 0) begin : g_left
                assign w_ps_in[i][j] = '0;
                assign w_en_left[K]  = w_en_top[K];
            end else begin : g_right
                assign w_ps_in[i][j] = w_ps_out[i][j-1];
                assign w_en_left[K]  = w_en_right[K-1];
            end

            mac_pe #(
                .DW (DW),
                .PW (PW)
            ) u_pe (
                .CLK      (CLK),
                .RSTN     (RSTN),
                .W_IN     (r_active[i][j]),
                .ENTop    (w_en_top[K]),
                .ENDown   (w_en_down[K]),
                .ENLeft   (w_en_left[K]),
                .ENRight  (w_en_right[K]),
                .A_IN     (w_a_in[i][j]),
                .A_OUT    (w_a_out[i][j]),
                .PSUM_IN  (w_ps_in[i][j]),
                .PSUM_OUT (w_ps_out[i][j])
            );
        end

        assign ODATA[(ROWS-1-i)*PW +: PW] = w_ps_out[i][COLS-1];
        assign OVALID[i]                  = w_en_right[i*COLS + COLS-1];
    end

    assign BUSY = (|w_en_down) || (|w_en_right);

endmodule
`default_nettype wire

// File: tb/tb_mac_array_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_array_ws
// Brief    : Directed self-checking bench for mac_array_ws (4x4, DW=8, PW=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_array_ws;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DW    = 8;
    localparam int PW    = 16;
    localparam int DEPTH = 1024;

    typedef int vec_t [4];

    logic               CLK = 1'b0;
    logic               RSTN;
    logic               W_VALID;
    logic               W_READY;
    logic [COLS*DW-1:0] WDATA;
    logic [COLS*DW-1:0] IDATA;
    logic [COLS-1:0]    ICOL_VALID;
    logic [ROWS*PW-1:0] ODATA;
    logic [ROWS-1:0]    OVALID;
    logic               W_ACTIVE;
    logic               BUSY;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    bit sched_v [0:DEPTH-1];
    int sched_a [0:DEPTH-1][0:COLS-1];
    bit exp_v   [0:DEPTH-1][0:ROWS-1];
    int exp_d   [0:DEPTH-1][0:ROWS-1];

    mac_array_ws #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DW   (DW),
        .PW   (PW)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .W_VALID    (W_VALID),
        .W_READY    (W_READY),
        .WDATA      (WDATA),
        .IDATA      (IDATA),
        .ICOL_VALID (ICOL_VALID),
        .ODATA      (ODATA),
        .OVALID     (OVALID),
        .W_ACTIVE   (W_ACTIVE),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int row_val(input int i);
        logic signed [PW-1:0] v;
        v = ODATA[(ROWS-1-i)*PW +: PW];
        return int'(v);
    endfunction

    function automatic logic [COLS*DW-1:0] wrow(input int c0, input int c1,
                                                input int c2, input int c3);
        return {c0[7:0], c1[7:0], c2[7:0], c3[7:0]};
    endfunction

    task automatic clear_sched();
        for (int k = 0; k < DEPTH; k++) begin
            sched_v[k] = 1'b0;
            for (int r = 0; r < ROWS; r++) exp_v[k][r] = 1'b0;
        end
    endtask

    // Column 0 driven at cycle t; row i result expected at t+i+COLS.
    task automatic push_vec(input int t, input vec_t a, input vec_t r);
        sched_v[t] = 1'b1;
        for (int j = 0; j < COLS; j++) sched_a[t][j] = a[j];
        for (int i = 0; i < ROWS; i++) begin
            exp_v[t+i+COLS][i] = 1'b1;
            exp_d[t+i+COLS][i] = r[i];
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        if (mon_en) begin
            for (int i = 0; i < ROWS; i++) begin
                check_val($sformatf("ovalid[%0d]", i), OVALID[i], exp_v[cyc][i]);
                if (exp_v[cyc][i])
                    check_val($sformatf("odata[%0d]", i), row_val(i), exp_d[cyc][i]);
            end
        end
        ICOL_VALID = '0;
        IDATA      = '0;
        for (int j = 0; j < COLS; j++) begin
            int idx;
            idx = cyc - j;
            if (idx >= 0 && sched_v[idx]) begin
                ICOL_VALID[j] = 1'b1;
                IDATA[(COLS-1-j)*DW +: DW] = sched_a[idx][j][DW-1:0];
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load_row(input logic [COLS*DW-1:0] d);
        W_VALID = 1'b1;
        WDATA   = d;
        tick();
        W_VALID = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!W_READY && k < 40) begin
            tick();
            k++;
        end
        if (!W_READY) check_val("swap_timeout", 0, 1);
    endtask

    task automatic load_all(input logic [COLS*DW-1:0] d);
        for (int r = 0; r < ROWS; r++) load_row(d);
        wait_ready();
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        RSTN = 1'b0; W_VALID = 1'b0; WDATA = '0; IDATA = '0; ICOL_VALID = '0;
        clear_sched();
        run(2);
        check_val("rst_wready",  W_READY,  0);
        check_val("rst_ovalid",  OVALID,   0);
        check_val("rst_odata",   ODATA,    0);
        check_val("rst_busy",    BUSY,     0);
        check_val("rst_wactive", W_ACTIVE, 0);
        RSTN = 1'b1;
        tick();
        check_val("idle_wready",  W_READY,  1);
        check_val("idle_wactive", W_ACTIVE, 0);
        mon_en = 1'b1;

        // Zero weights before any load: results still flow out as 0.
        push_vec(cyc+1, '{1, 2, 3, 4}, '{0, 0, 0, 0});
        run(10);
        check_val("busy_drained0", BUSY, 0);

        // Load all-ones.
        for (int r = 0; r < ROWS; r++) begin
            load_row(wrow(1, 1, 1, 1));
            check_val($sformatf("load1_wready_r%0d", r), W_READY, (r == ROWS-1) ? 0 : 1);
        end
        check_val("load1_wactive_pre", W_ACTIVE, 0);
        tick();
        check_val("load1_wactive", W_ACTIVE, 1);
        check_val("load1_wready_post", W_READY, 1);

        // Basic MAC plus a mixed-sign vector.
        t0 = cyc + 1;
        push_vec(t0,   '{1, 2, 3, 4},  '{10, 10, 10, 10});
        push_vec(t0+2, '{5, -3, 7, 0}, '{9, 9, 9, 9});
        run(2);
        check_val("busy_inflight", BUSY, 1);
        run(12);
        check_val("busy_drained1", BUSY, 0);

        // Deferred swap: stream for 6 cycles while shadow fills with 2s.
        t0 = cyc + 1;
        for (int k = 0; k < 6; k++) push_vec(t0+k, '{1, 2, 3, 4}, '{10, 10, 10, 10});
        for (int r = 0; r < ROWS; r++) load_row(wrow(2, 2, 2, 2));
        check_val("defer_full", W_READY, 0);
        while (cyc < t0 + 12) tick();
        check_val("defer_busy_last", BUSY, 1);
        check_val("defer_wready_last", W_READY, 0);
        tick();
        check_val("defer_busy_zero", BUSY, 0);
        check_val("defer_not_swapped", W_READY, 0);
        tick();
        check_val("defer_swapped", W_READY, 1);
        push_vec(cyc+1, '{1, 2, 3, 4}, '{20, 20, 20, 20});
        run(10);

        // Back-pressure: identity into shadow, then junk offered while FULL.
        t0 = cyc + 1;
        for (int k = 0; k < 8; k++) push_vec(t0+k, '{1, 2, 3, 4}, '{20, 20, 20, 20});
        load_row(wrow(1, 0, 0, 0));
        load_row(wrow(0, 1, 0, 0));
        load_row(wrow(0, 0, 1, 0));
        load_row(wrow(0, 0, 0, 1));
        W_VALID = 1'b1;
        for (int k = 0; k < 9; k++) begin
            WDATA = wrow(k*17 + 5, 99 - k, -k - 3, 60 + k);
            tick();
        end
        check_val("bp_full_wready", W_READY, 0);
        W_VALID = 1'b0;
        wait_ready();
        push_vec(cyc+1, '{1, 2, 3, 4},   '{1, 2, 3, 4});
        push_vec(cyc+2, '{5, -6, 7, -8}, '{5, -6, 7, -8});
        run(12);

        // Signed math.
        load_all(wrow(-1, -1, -1, -1));
        push_vec(cyc+1, '{-128, 5, 0, 3}, '{120, 120, 120, 120});
        run(10);

        // Saturation / wrap.
        load_all(wrow(127, 127, 127, 127));
`ifdef MAC_ARRAY_SAT_EN
        push_vec(cyc+1, '{127, 127, 127, 127},     '{32767, 32767, 32767, 32767});
        push_vec(cyc+2, '{-128, -128, -128, -128}, '{-32768, -32768, -32768, -32768});
`else
        push_vec(cyc+1, '{127, 127, 127, 127},     '{-1020, -1020, -1020, -1020});
        push_vec(cyc+2, '{-128, -128, -128, -128}, '{512, 512, 512, 512});
`endif
        run(12);

        // Reset mid-stream with a partial shadow load pending.
        load_row(wrow(9, 9, 9, 9));
        load_row(wrow(9, 9, 9, 9));
        t0 = cyc + 1;
        push_vec(t0, '{1, 1, 1, 1}, '{508, 508, 508, 508});
        while (cyc < t0 + COLS) tick();
        check_val("mid_ovalid0", OVALID[0], 1);
        mon_en = 1'b0;
        clear_sched();
        RSTN = 1'b0;
        tick();
        check_val("mid_rst_odata",   ODATA,    0);
        check_val("mid_rst_ovalid",  OVALID,   0);
        check_val("mid_rst_wactive", W_ACTIVE, 0);
        check_val("mid_rst_wready",  W_READY,  0);
        check_val("mid_rst_busy",    BUSY,     0);
        RSTN = 1'b1;
        tick();
        check_val("mid_idle_wready", W_READY, 1);
        mon_en = 1'b1;
        load_row(wrow(1, 0, 0, 0));
        load_row(wrow(0, 1, 0, 0));
        load_row(wrow(0, 0, 1, 0));
        load_row(wrow(0, 0, 0, 1));
        wait_ready();
        check_val("mid_reload_wactive", W_ACTIVE, 1);
        push_vec(cyc+1, '{3, 1, 4, 1}, '{3, 1, 4, 1});
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
